// File: rtl/pc_unit.sv
// Program-counter unit: sequential increment, relative branch, absolute jump,
// and CALL/RET backed by a small circular return-address stack.
module pc_unit #(
    parameter int WIDTH     = 16,
    parameter int STEP      = 2,
    parameter int RESET_VEC = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       STALL,
    input  logic [2:0]                 PC_OP,
    input  logic                       COND,
    input  logic [WIDTH-1:0]           OFFSET,
    input  logic [WIDTH-1:0]           TARGET,
    output logic [WIDTH-1:0]           PC,
    output logic [WIDTH-1:0]           PC_PLUS,
    output logic [$clog2(RAS_DEPTH):0] RAS_COUNT,
    output logic                       RAS_OVF,
    output logic                       RAS_UNF
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;

    logic [WIDTH-1:0] pc_reg, pc_next, pc_plus;
    logic [PW-1:0]    top_reg, top_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             push;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    assign pc_plus = pc_reg + WIDTH'(STEP);

    always_comb begin
        pc_next    = pc_plus;
        top_next   = top_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        push       = 1'b0;
        case (PC_OP)
            OP_BRANCH: begin
                if (COND) pc_next = pc_reg + OFFSET;
            end
            OP_JUMP: pc_next = TARGET;
            OP_CALL: begin
                // A full stack still takes the push, overwriting the oldest entry.
                push     = 1'b1;
                pc_next  = TARGET;
                top_next = top_reg + PW'(1);
                if (count_reg == FULL) ovf_next = 1'b1;
                else                   count_next = count_reg + CW'(1);
            end
            OP_RET: begin
                if (count_reg == '0) begin
                    unf_next = 1'b1;
                end else begin
                    pc_next    = ras_mem[top_reg];
                    top_next   = top_reg - PW'(1);
                    count_next = count_reg - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_reg    <= WIDTH'(RESET_VEC);
            top_reg   <= PW'(RAS_DEPTH - 1);
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else if (!STALL) begin
            pc_reg    <= pc_next;
            top_reg   <= top_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    // Storage kept free of reset so it maps onto plain RAM.
    always_ff @(posedge CLK) begin
        if (!RESET && !STALL && push) ras_mem[top_next] <= pc_plus;
    end

    assign PC        = pc_reg;
    assign PC_PLUS   = pc_plus;
    assign RAS_COUNT = count_reg;
    assign RAS_OVF   = ovf_reg;
    assign RAS_UNF   = unf_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboarded directed test of pc_unit (WIDTH=16, STEP=2, RESET_VEC=0, RAS_DEPTH=4).
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  pc_op;
    logic        cond;
    logic [15:0] offset;
    logic [15:0] target;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic [2:0]  ras_count;
    logic        ras_ovf;
    logic        ras_unf;

    localparam logic [2:0] INC = 3'b000, BR = 3'b001, JMP = 3'b010,
                           CALL = 3'b011, RET = 3'b100;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;
    bit   done   = 0;

    pc_unit #(.WIDTH(16), .STEP(2), .RESET_VEC(0), .RAS_DEPTH(4)) dut (
        .CLK(clk), .RESET(reset), .STALL(stall), .PC_OP(pc_op), .COND(cond),
        .OFFSET(offset), .TARGET(target), .PC(pc), .PC_PLUS(pc_plus),
        .RAS_COUNT(ras_count), .RAS_OVF(ras_ovf), .RAS_UNF(ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one op for the next rising edge and queue the state expected after it.
    task automatic step(input string name, input logic rst, input logic stl,
                        input logic [2:0] op, input logic c, input logic [15:0] off,
                        input logic [15:0] tgt, input logic [15:0] e_pc,
                        input logic [2:0] e_cnt, input logic e_ovf, input logic e_unf);
        exp_t e;
        @(negedge clk);
        reset  = rst;
        stall  = stl;
        pc_op  = op;
        cond   = c;
        offset = off;
        target = tgt;
        e.name = name; e.pc = e_pc; e.cnt = e_cnt; e.ovf = e_ovf; e.unf = e_unf;
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a new state after every rising edge.
    initial begin
        exp_t e;
        logic [15:0] e_plus;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                e_plus = e.pc + 16'd2;
                tests += 5;
                if (pc !== e.pc) begin
                    failed++;
                    $display("FAIL %s pc: got %h expected %h", e.name, pc, e.pc);
                end
                if (pc_plus !== e_plus) begin
                    failed++;
                    $display("FAIL %s pc_plus: got %h expected %h", e.name, pc_plus, e_plus);
                end
                if (ras_count !== e.cnt) begin
                    failed++;
                    $display("FAIL %s ras_count: got %0d expected %0d", e.name, ras_count, e.cnt);
                end
                if (ras_ovf !== e.ovf) begin
                    failed++;
                    $display("FAIL %s ras_ovf: got %b expected %b", e.name, ras_ovf, e.ovf);
                end
                if (ras_unf !== e.unf) begin
                    failed++;
                    $display("FAIL %s ras_unf: got %b expected %b", e.name, ras_unf, e.unf);
                end
                $display("[TB] %-14s pc=%h pc_plus=%h cnt=%0d ovf=%b unf=%b",
                         e.name, pc, pc_plus, ras_count, ras_ovf, ras_unf);
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b1; stall = 1'b0; pc_op = INC; cond = 1'b0;
        offset = 16'h0; target = 16'h0;

        //    name             rst stl op    c  offset    target    pc        cnt ovf unf
        step("reset",          1, 0, INC,  0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        step("inc1",           0, 0, INC,  0, 16'h0000, 16'h0000, 16'h0002, 0, 0, 0);
        step("inc2",           0, 0, INC,  0, 16'h0000, 16'h0000, 16'h0004, 0, 0, 0);
        step("inc3",           0, 0, INC,  0, 16'h0000, 16'h0000, 16'h0006, 0, 0, 0);
        step("jump10",         0, 0, JMP,  0, 16'h0000, 16'h0010, 16'h0010, 0, 0, 0);
        step("br_taken_neg",   0, 0, BR,   1, 16'hFFF8, 16'h0000, 16'h0008, 0, 0, 0);
        step("br_not_taken",   0, 0, BR,   0, 16'h0040, 16'h0000, 16'h000A, 0, 0, 0);
        step("jump_fffe",      0, 0, JMP,  0, 16'h0000, 16'hFFFE, 16'hFFFE, 0, 0, 0);
        step("inc_wrap",       0, 0, INC,  0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        step("jump_1234",      0, 0, JMP,  0, 16'h0000, 16'h1234, 16'h1234, 0, 0, 0);
        step("op111_inc",      0, 0, 3'b111, 1, 16'h0100, 16'h9999, 16'h1236, 0, 0, 0);
        step("jump_100",       0, 0, JMP,  0, 16'h0000, 16'h0100, 16'h0100, 0, 0, 0);
        step("call_200",       0, 0, CALL, 0, 16'h0000, 16'h0200, 16'h0200, 1, 0, 0);
        step("call_300",       0, 0, CALL, 0, 16'h0000, 16'h0300, 16'h0300, 2, 0, 0);
        step("ret_a",          0, 0, RET,  0, 16'h0000, 16'h0000, 16'h0202, 1, 0, 0);
        step("ret_b",          0, 0, RET,  0, 16'h0000, 16'h0000, 16'h0102, 0, 0, 0);
        step("call5_1",        0, 0, CALL, 0, 16'h0000, 16'h1000, 16'h1000, 1, 0, 0);
        step("call5_2",        0, 0, CALL, 0, 16'h0000, 16'h2000, 16'h2000, 2, 0, 0);
        step("call5_3",        0, 0, CALL, 0, 16'h0000, 16'h3000, 16'h3000, 3, 0, 0);
        step("call5_4",        0, 0, CALL, 0, 16'h0000, 16'h4000, 16'h4000, 4, 0, 0);
        step("call5_ovf",      0, 0, CALL, 0, 16'h0000, 16'h5000, 16'h5000, 4, 1, 0);
        step("ret5_1",         0, 0, RET,  0, 16'h0000, 16'h0000, 16'h4002, 3, 1, 0);
        step("ret5_2",         0, 0, RET,  0, 16'h0000, 16'h0000, 16'h3002, 2, 1, 0);
        step("ret5_3",         0, 0, RET,  0, 16'h0000, 16'h0000, 16'h2002, 1, 1, 0);
        step("ret5_4",         0, 0, RET,  0, 16'h0000, 16'h0000, 16'h1002, 0, 1, 0);
        step("ret5_unf",       0, 0, RET,  0, 16'h0000, 16'h0000, 16'h1004, 0, 1, 1);
        step("stall_call",     0, 1, CALL, 0, 16'h0000, 16'h7000, 16'h1004, 0, 1, 1);
        step("stall_inc",      0, 1, INC,  0, 16'h0000, 16'h0000, 16'h1004, 0, 1, 1);
        step("stall_call2",    0, 1, CALL, 0, 16'h0000, 16'h7000, 16'h1004, 0, 1, 1);
        step("call_7000",      0, 0, CALL, 0, 16'h0000, 16'h7000, 16'h7000, 1, 1, 1);
        step("stall_ret",      0, 1, RET,  0, 16'h0000, 16'h0000, 16'h7000, 1, 1, 1);
        step("ret_1006",       0, 0, RET,  0, 16'h0000, 16'h0000, 16'h1006, 0, 1, 1);
        step("jump_500",       0, 0, JMP,  0, 16'h0000, 16'h0500, 16'h0500, 0, 1, 1);
        step("rst_stall_call", 1, 1, CALL, 0, 16'h0000, 16'h8000, 16'h0000, 0, 0, 0);
        step("ret_no_push",    0, 0, RET,  0, 16'h0000, 16'h0000, 16'h0002, 0, 0, 1);
        step("call_a00",       0, 0, CALL, 0, 16'h0000, 16'h0A00, 16'h0A00, 1, 0, 1);
        step("rst_call",       1, 0, CALL, 0, 16'h0000, 16'h0B00, 16'h0000, 0, 0, 0);
        step("ret_after_rst",  0, 0, RET,  0, 16'h0000, 16'h0000, 16'h0002, 0, 0, 1);
        step("br_taken_pos",   0, 0, BR,   1, 16'h0040, 16'h0000, 16'h0042, 0, 0, 1);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (exp_q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expected results left, required 0", exp_q.size());
        end
        done = 1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #20000;
        if (!done) begin
            $display("FAIL timeout: simulation did not complete, required completion");
            $fatal(1, "timeout");
        end
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the accumulator processor; next generation of the fixed PC+2 incrementer.
- Holds the architectural PC and selects the next PC each cycle: sequential increment, conditional relative branch, absolute jump, call or return.
- Includes a small hardware return-address stack (RAS) so CALL/RET do not need memory traffic.
- Sits between the control unit (which supplies PC_OP, COND, STALL) and instruction memory (which consumes PC).

Parameters:
- WIDTH, 16, PC/address width in bits
- STEP, 2, increment per sequential instruction (bytes per instruction word)
- RESET_VEC, 0, PC value loaded on reset
- RAS_DEPTH, 4, number of return-address stack entries (power of two, >= 2)

Ports:
- CLK  input  1  system clock, all state updates on the rising edge
- RESET  input  1  synchronous, active-high reset
- STALL  input  1  when 1, hold PC and RAS unchanged
- PC_OP  input  3  000 INC, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET; 101-111 treated as INC
- COND  input  1  branch condition, used only by BRANCH
- OFFSET  input  WIDTH  two's-complement branch offset, relative to the current PC
- TARGET  input  WIDTH  absolute target for JUMP/CALL
- PC  output  WIDTH  current PC (registered)
- PC_PLUS  output  WIDTH  PC+STEP (combinational from PC)
- RAS_COUNT  output  clog2(RAS_DEPTH)+1  valid RAS entries (registered)
- RAS_OVF  output  1  sticky: a CALL pushed onto a full RAS
- RAS_UNF  output  1  sticky: a RET popped an empty RAS

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RESET). RESET has priority over STALL and PC_OP.
- Reset values:
  - PC = RESET_VEC; PC_PLUS therefore = RESET_VEC+STEP.
  - RAS_COUNT = 0; RAS_OVF = 0; RAS_UNF = 0.
  - RAS storage contents are don't-care.
- STALL=1 (and RESET=0): PC, RAS pointer, RAS_COUNT, RAS contents and flags all hold; PC_OP is ignored.
- Otherwise the next-PC is loaded at the rising edge, so PC changes one cycle after the op is presented:
  - INC: PC <= PC+STEP.
  - BRANCH: if COND=1, PC <= PC+OFFSET; else PC <= PC+STEP.
  - JUMP: PC <= TARGET.
  - CALL: push PC+STEP onto the RAS, then PC <= TARGET.
  - RET: pop the top entry and PC <= that entry.
- Arithmetic: all additions are modulo 2^WIDTH with no carry out, so wrap-around is silent. There are no alignment checks; targets are used as given.
- RAS is a circular buffer with a top pointer:
  - Push writes at top+1 and increments RAS_COUNT, saturating at RAS_DEPTH.
  - Pop reads at top, decrements top and decrements RAS_COUNT.
- CALL with RAS_COUNT == RAS_DEPTH:
  - The push still occurs and overwrites the oldest entry.
  - RAS_COUNT stays at RAS_DEPTH; RAS_OVF <= 1.
  - The jump proceeds normally.
- RET with RAS_COUNT == 0:
  - No pop; the pointer is unchanged.
  - PC <= PC+STEP (treated as INC); RAS_UNF <= 1.
- RAS_OVF and RAS_UNF stay set until RESET.
- RESET asserted mid-sequence (for example on the cycle of a CALL): the reset values win and no push occurs.
- A CALL and a RET cannot be presented in the same cycle, because PC_OP encodes a single op.

Test Plan:
- Reset then 3 cycles of INC (WIDTH=16, STEP=2, RESET_VEC=0) -> PC 0x0000, 0x0002, 0x0004, 0x0006; PC_PLUS always PC+2.
- PC=0x0010: BRANCH OFFSET=0xFFF8 COND=1 -> PC=0x0008; then BRANCH OFFSET=0x0040 COND=0 -> PC=0x000A.
- PC=0xFFFE, INC -> PC=0x0000 (wrap); then JUMP TARGET=0x1234 -> 0x1234.
- At PC=0x0100 CALL TARGET=0x0200, then CALL TARGET=0x0300, RET, RET -> PC 0x0200, 0x0300, 0x0202, 0x0102; RAS_COUNT 1, 2, 1, 0; no flags.
- Five CALLs with RAS_DEPTH=4 -> RAS_COUNT=4, RAS_OVF=1; then five RETs -> the first four return the newest-to-oldest surviving addresses; the fifth gives PC+2 and RAS_UNF=1.
- STALL=1 held for 3 cycles during CALL/INC ops -> PC, RAS_COUNT and flags unchanged. RESET=1 together with STALL=1 and a CALL -> PC=RESET_VEC and RAS_COUNT=0 on the next edge.
